reg_reader: RTL and testbench
=============================

# reg_reader

Sequential read-back engine that pairs with the register writer: on a `go` pulse it walks the register-file read port through the same five-register sequence (r8, then r9–r12 upward or r7–r4 downward) and accumulates the read data into a running sum. It sits beside the register file in the Lab 3 datapath and drives one asynchronous (combinational) read port. `done` reports that a complete read-back has finished and `sum` holds the result.

## Interface
- `WIDTH`, default 32, data width of the register-file read port and of `sum`.
- `BASE_REG`, default 8, first register read in every sequence.
- `clock`  input  1  the single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset. Low forces the reset state immediately, independent of `clock`.
- `go`  input  1  start request. Level-sensitive: held high to arm, falling edge launches.
- `direction`  input  1  1 = read upward (BASE_REG+1..+4), 0 = read downward (BASE_REG-1..-4).
- `rdata`  input  WIDTH  register-file read data for `regnum`, valid in the same cycle.
- `regnum`  output  5  register-file read address.
- `sum`  output  WIDTH  registered accumulated sum of the five reads.
- `busy`  output  1  high while in any read state.
- `done`  output  1  high while in DONE.

## Operation
- States: IDLE, ARM, RD0, RD1, RD2, RD3, RD4, DONE. One-hot or binary encoding is permitted; behaviour is identical.
- IDLE: if `go`=1, go to ARM, else stay.
- ARM: clear `sum` to 0. If `go`=1, stay. If `go`=0, latch `direction` into `dir_q` and go to RD0.
- RD0: `regnum`=BASE_REG.
- RDk (k=1..4): `regnum`=BASE_REG+k if `dir_q`=1, else BASE_REG-k.
- Each RD state adds `rdata` into `sum` at the closing edge. RDk advances to RDk+1 unconditionally, and RD4 goes to DONE. `go` is ignored in RD states.
- DONE: `sum` holds its value. If `go`=1, go to ARM, which clears `sum`. Otherwise stay.
- `regnum`=0 in IDLE, ARM and DONE.
- Arithmetic: `sum` is an unsigned modulo-2^WIDTH addition, and overflow wraps silently. `regnum` arithmetic is 5-bit and cannot wrap for BASE_REG=8. BASE_REG must lie in 4..27; this is enforced by an elaboration-time check.
- `direction` changes after the ARM→RD0 edge have no effect until the next run.

## Timing
- Reset values: state=IDLE, `regnum`=0, `sum`=0, `busy`=0, `done`=0, `dir_q`=0.
- Reset asserted mid-sequence: the same values apply asynchronously, and the partial sum is discarded. After reset is released, the block stays in IDLE until `go`=1 is sampled.
- The first edge after `go` is sampled low in ARM enters RD0.
- The five read cycles are RD0..RD4, with `busy`=1 throughout.
- The sixth edge enters DONE, with `done`=1 and the final `sum` valid in the same cycle.
- Latency from the `go`-low sample to `done`: 6 cycles.
- `rdata` must be stable before each rising edge in the RD states. The block adds no pipeline stage on the read path.
- `go` held high indefinitely keeps the block in ARM with `sum`=0.
- A one-cycle `go` pulse yields IDLE→ARM→RD0.
- Simultaneous `go`=1 in DONE: leave DONE on that edge, and `done` drops the next cycle.
- `regnum`, `busy` and `done` are decoded combinationally from the state register and are glitch-tolerant only at the edge.

## Structure
- Shared package `reg_rw_pkg` holds:
  - the state enum `rr_state_t`;
  - the constant `NUM_READS`=5;
  - the default `BASE_REG`=8, shared with the writer so both walk identical sequences.
- Sub-module `dffe_arn` is a single-bit enable flip-flop with asynchronous active-low reset. It is used for the state bits and `dir_q` and is reusable by later blocks.
- The `sum` register and the state logic live in `reg_reader`. No other hierarchy.

## Test plan
- Reset during RD2: `reset` low asynchronously → `regnum`=0, `sum`=0, `busy`=0, `done`=0 before the next edge. After release with `go`=0 the block stays IDLE.
- Upward run: regfile rN=N, `go` 1 for 3 cycles then 0, `direction`=1 → `regnum` sequence 8,9,10,11,12. `sum`=50 with `done`=1 on the 6th edge.
- Downward run: same stimulus with `direction`=0 → `regnum` 8,7,6,5,4, `sum`=30. `direction` toggled during RD1..RD4 → no change.
- Wrap: WIDTH=8, all five registers hold 0x40 → `sum`=0x40 (320 mod 256). `done`=1.
- Restart from DONE: `go`=1 in DONE → ARM next cycle, `sum`=0 and `done`=0. A second downward run gives `sum`=30.
- `go` asserted during RD3 → ignored. The sequence completes normally and reaches DONE on schedule.

Source files
------------

// File: rtl/reg_rw_pkg.sv
// Shared definitions for the register read-back / write engines.
// Both engines walk the same five-register sequence around BASE_REG.
package reg_rw_pkg;

    localparam int NUM_READS        = 5;
    localparam int DEFAULT_BASE_REG = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RD0  = 3'd2,
        ST_RD1  = 3'd3,
        ST_RD2  = 3'd4,
        ST_RD3  = 3'd5,
        ST_RD4  = 3'd6,
        ST_DONE = 3'd7
    } rr_state_t;

    // Offset of the register read in a given read state (0 for RD0).
    function automatic logic [2:0] rd_slot(input rr_state_t s);
        logic [2:0] k;
        k = 3'd0;
        unique case (s)
            ST_RD1:  k = 3'd1;
            ST_RD2:  k = 3'd2;
            ST_RD3:  k = 3'd3;
            ST_RD4:  k = 3'd4;
            default: k = 3'd0;
        endcase
        return k;
    endfunction

    // True in any of the five read states.
    function automatic logic is_rd(input rr_state_t s);
        return (s == ST_RD0) || (s == ST_RD1) || (s == ST_RD2) ||
               (s == ST_RD3) || (s == ST_RD4);
    endfunction

endpackage

// File: rtl/dffe_arn.sv
// Single-bit flip-flop with enable and asynchronous active-low reset.
// Resets to 0; holds its value while en is low.
module dffe_arn (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    // Capture d on enabled rising edges; clear immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_reader.sv
// Register-file read-back engine: on a go falling edge, reads r[BASE],
// then four neighbours up or down, and accumulates them into sum.
module reg_reader
    import reg_rw_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int BASE_REG = DEFAULT_BASE_REG
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             direction,
    input  logic [WIDTH-1:0] rdata,
    output logic [4:0]       regnum,
    output logic [WIDTH-1:0] sum,
    output logic             busy,
    output logic             done
);

    // The walked window must stay inside r0..r31 without wrapping.
    if ((BASE_REG - (NUM_READS - 1) < 0) ||
        (BASE_REG + (NUM_READS - 1) > 31)) begin : g_bad_base
        $error("reg_reader: BASE_REG out of range 4..27");
    end

    localparam logic [4:0] BASE5 = 5'(BASE_REG);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    rr_state_t        state;
    rr_state_t        state_nx;
    logic             dir_q;
    logic             dir_d;
    logic             dir_en;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [2:0]       slot;
    logic             in_rd;

    assign state   = rr_state_t'(state_q);
    assign state_d = state_nx;
    assign in_rd   = is_rd(state);
    assign slot    = rd_slot(state);

    // State register, one reusable flop per encoded bit.
    for (genvar i = 0; i < 3; i++) begin : g_state
        dffe_arn u_bit (
            .clk   (clock),
            .rst_n (reset),
            .en    (1'b1),
            .d     (state_d[i]),
            .q     (state_q[i])
        );
    end

    // Direction is sampled only on the ARM->RD0 transition.
    assign dir_en = (state == ST_ARM) && !go;
    assign dir_d  = direction;

    dffe_arn u_dir (
        .clk   (clock),
        .rst_n (reset),
        .en    (dir_en),
        .d     (dir_d),
        .q     (dir_q)
    );

    // Next-state logic: go arms/launches, read states advance freely.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (go)  state_nx = ST_ARM;
            ST_ARM:  if (!go) state_nx = ST_RD0;
            ST_RD0:  state_nx = ST_RD1;
            ST_RD1:  state_nx = ST_RD2;
            ST_RD2:  state_nx = ST_RD3;
            ST_RD3:  state_nx = ST_RD4;
            ST_RD4:  state_nx = ST_DONE;
            ST_DONE: if (go)  state_nx = ST_ARM;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Sum clears on entry to ARM and accumulates one read per RD cycle.
    always_comb begin
        sum_d = sum_q;
        if (state_nx == ST_ARM) begin
            sum_d = '0;
        end else if (in_rd) begin
            sum_d = sum_q + rdata;
        end
    end

    // Accumulator register; a reset discards any partial sum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    // Read address decode: base in RD0, base +/- k in RDk, else 0.
    always_comb begin
        regnum = 5'd0;
        if (in_rd) begin
            if (dir_q) begin
                regnum = BASE5 + {2'b00, slot};
            end else begin
                regnum = BASE5 - {2'b00, slot};
            end
        end
    end

    assign sum  = sum_q;
    assign busy = in_rd;
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_reg_reader.sv
// Self-checking bench for reg_reader: table runs, corner sequences,
// and randomized runs against a sum-of-window reference model.
module tb_reg_reader;

    logic        clock;
    logic        reset;
    logic        go;
    logic        direction;
    logic [31:0] rdata;
    logic [4:0]  regnum;
    logic [31:0] sum;
    logic        busy;
    logic        done;
    logic [7:0]  rdata8;
    logic [4:0]  regnum8;
    logic [7:0]  sum8;
    logic        busy8;
    logic        done8;

    logic [31:0] regs  [32];
    logic [7:0]  regs8 [32];

    int checks = 0;
    int errors = 0;

    assign rdata  = regs[regnum];
    assign rdata8 = regs8[regnum8];

    reg_reader #(.WIDTH(32), .BASE_REG(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .direction (direction),
        .rdata     (rdata),
        .regnum    (regnum),
        .sum       (sum),
        .busy      (busy),
        .done      (done)
    );

    reg_reader #(.WIDTH(8), .BASE_REG(8)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .direction (direction),
        .rdata     (rdata8),
        .regnum    (regnum8),
        .sum       (sum8),
        .busy      (busy8),
        .done      (done8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic        dir;
        logic [31:0] mult;
        logic [31:0] addc;
        logic [7:0]  fill8;
        int          hold;
        logic        toggle;
        logic        go3;
        logic [31:0] exp_sum;
        logic [7:0]  exp8;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int exp_reg(input logic dir, input int k);
        return dir ? 8 + k : 8 - k;
    endfunction

    function automatic logic [31:0] model_sum(input logic dir);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < 5; k++) s += regs[exp_reg(dir, k)];
        return s;
    endfunction

    function automatic logic [7:0] model_sum8(input logic dir);
        logic [7:0] s;
        s = 8'd0;
        for (int k = 0; k < 5; k++) s += regs8[exp_reg(dir, k)];
        return s;
    endfunction

    task automatic run_seq(input logic dir, input int hold,
                           input logic toggle, input logic go3,
                           input logic [31:0] exp_sum,
                           input logic [7:0] exp8, input string tag);
        go = 1'b1;
        direction = dir;
        tick();
        chk({tag, " arm sum"}, sum, 32'd0);
        chk({tag, " arm done"}, 32'(done), 32'd0);
        chk({tag, " arm busy"}, 32'(busy), 32'd0);
        chk({tag, " arm regnum"}, 32'(regnum), 32'd0);
        for (int h = 1; h < hold; h++) tick();
        chk({tag, " hold sum"}, sum, 32'd0);
        go = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s rd%0d regnum", tag, k), 32'(regnum),
                32'(exp_reg(dir, k)));
            chk($sformatf("%s rd%0d busy", tag, k), 32'(busy), 32'd1);
            chk($sformatf("%s rd%0d done", tag, k), 32'(done), 32'd0);
            if (toggle) direction = ~direction;
            if (go3) go = (k == 3);
            tick();
        end
        go = 1'b0;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " done busy"}, 32'(busy), 32'd0);
        chk({tag, " done regnum"}, 32'(regnum), 32'd0);
        chk({tag, " sum"}, sum, exp_sum);
        chk({tag, " sum8"}, 32'(sum8), 32'(exp8));
        chk({tag, " done8"}, 32'(done8), 32'd1);
        tick();
        chk({tag, " done hold"}, 32'(done), 32'd1);
        chk({tag, " sum hold"}, sum, exp_sum);
        direction = dir;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'd1, 32'd0, 8'h40, 3, 1'b0, 1'b0,
                    32'd50, 8'h40};
        vecs[1] = '{1'b0, 32'd1, 32'd0, 8'h10, 3, 1'b1, 1'b0,
                    32'd30, 8'h50};
        vecs[2] = '{1'b1, 32'd0, 32'h4000_0000, 8'hFF, 1, 1'b0, 1'b0,
                    32'h4000_0000, 8'hFB};
        vecs[3] = '{1'b0, 32'h10, 32'd1, 8'h33, 2, 1'b1, 1'b1,
                    32'h1E5, 8'hFF};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'd0, 8'h00, 20, 1'b0, 1'b1,
                    32'hFFFF_FFCE, 8'h00};
        vecs[5] = '{1'b0, 32'd1, 32'd0, 8'h40, 1, 1'b0, 1'b0,
                    32'd30, 8'h40};

        for (int n = 0; n < 32; n++) begin
            regs[n]  = 32'(n);
            regs8[n] = 8'(n);
        end
        reset = 1'b0;
        go = 1'b0;
        direction = 1'b0;
        #3;
        chk("rst regnum", 32'(regnum), 32'd0);
        chk("rst sum", sum, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        #19;
        reset = 1'b1;
        repeat (3) tick();
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle done", 32'(done), 32'd0);

        // Reset mid-run (in RD2) must clear everything before the next edge.
        go = 1'b1;
        direction = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        tick();
        chk("rd2 regnum", 32'(regnum), 32'd10);
        chk("rd2 sum", sum, 32'd17);
        chk("rd2 busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async regnum", 32'(regnum), 32'd0);
        chk("async sum", sum, 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async done", 32'(done), 32'd0);
        #1;
        reset = 1'b1;
        repeat (3) tick();
        chk("post rst busy", 32'(busy), 32'd0);
        chk("post rst done", 32'(done), 32'd0);
        chk("post rst regnum", 32'(regnum), 32'd0);
        chk("post rst sum", sum, 32'd0);

        for (int v = 0; v < 6; v++) begin
            for (int n = 0; n < 32; n++) begin
                regs[n]  = 32'(n) * vecs[v].mult + vecs[v].addc;
                regs8[n] = vecs[v].fill8;
            end
            run_seq(vecs[v].dir, vecs[v].hold, vecs[v].toggle,
                    vecs[v].go3, vecs[v].exp_sum, vecs[v].exp8,
                    $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 20; r++) begin
            logic dir;
            for (int n = 0; n < 32; n++) begin
                regs[n]  = $urandom;
                regs8[n] = 8'($urandom);
            end
            dir = 1'($urandom);
            run_seq(dir, int'($urandom_range(1, 4)), 1'($urandom),
                    1'($urandom), model_sum(dir), model_sum8(dir),
                    $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
